// File: rtl/sram_controller_pkg.sv
`default_nettype none
// sram_controller_pkg: state encoding, address map and SRAM bus widths.
// Revision: 1.0
package sram_controller_pkg;

   localparam int          SRAM_ADDR_W    = 18;
   localparam int          SRAM_DATA_W    = 16;
   localparam int          WORD_IDX_W     = SRAM_ADDR_W - 1;
   localparam logic [31:0] DATA_BASE_ADDR = 32'd1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Out-of-range addresses wrap modulo the SRAM word count.
   function automatic logic [WORD_IDX_W-1:0] word_index(input logic [31:0] addr);
      return WORD_IDX_W'((addr - DATA_BASE_ADDR) >> 2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// sram_wait_counter: counts WAIT_CYCLES cycles per half-access, wraps on terminal count.
// Revision: 1.0
module sram_wait_counter #(
   parameter int WAIT_CYCLES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic tc_o
);

   localparam int               CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WAIT_CYCLES - 1);

   logic [CNT_W-1:0] count_q, count_d;

   generate
      if (WAIT_CYCLES < 1) begin : g_param_check
         $error("WAIT_CYCLES must be at least 1");
      end
   endgenerate

   assign tc_o = (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = tc_o ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// sram_controller: maps 32-bit MEM-stage loads/stores onto two 16-bit SRAM half-accesses.
// Revision: 1.0
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int WAIT_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic                   wr_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   input  logic [SRAM_DATA_W-1:0] sram_dq_in,
   output logic [SRAM_DATA_W-1:0] sram_dq_out,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n
);

   state_e                 state_q, state_d;
   logic                   is_write_q, is_write_d;
   logic [WORD_IDX_W-1:0]  word_q, word_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [31:0]            rbuf_q, rbuf_d;
   logic [31:0]            rdata_q, rdata_d;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [SRAM_DATA_W-1:0] dq_q, dq_d;
   logic                   oe_q, oe_d;
   logic                   we_n_q, we_n_d;
   logic                   accept, in_access, tc;

   assign accept    = (state_q == ST_IDLE) && (rd_en || wr_en);
   assign in_access = (state_q == ST_LOW) || (state_q == ST_HIGH);

   sram_wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (accept),
      .enable_i (in_access),
      .tc_o     (tc)
   );

   always_comb begin
      state_d    = state_q;
      is_write_d = is_write_q;
      word_d     = word_q;
      wdata_d    = wdata_q;
      rbuf_d     = rbuf_q;
      rdata_d    = rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d    = ST_LOW;
               is_write_d = wr_en;
               word_d     = word_index(address);
               wdata_d    = write_data;
            end
         end
         ST_LOW: begin
            if (tc) begin
               state_d = ST_HIGH;
               if (!is_write_q) rbuf_d[15:0] = sram_dq_in;
            end
         end
         ST_HIGH: begin
            if (tc) begin
               state_d = ST_DONE;
               if (!is_write_q) rbuf_d[31:16] = sram_dq_in;
            end
         end
         default: begin
            state_d = ST_IDLE;
            if (!is_write_q) rdata_d = rbuf_q;
         end
      endcase

      // Bus outputs are registered from the next state so they are valid throughout LOW/HIGH.
      addr_d = addr_q;
      dq_d   = dq_q;
      oe_d   = 1'b0;
      we_n_d = 1'b1;
      if (state_d == ST_LOW) begin
         addr_d = {word_d, 1'b0};
         dq_d   = wdata_d[15:0];
         oe_d   = is_write_d;
         we_n_d = !is_write_d;
      end else if (state_d == ST_HIGH) begin
         addr_d = {word_d, 1'b1};
         dq_d   = wdata_d[31:16];
         oe_d   = is_write_d;
         we_n_d = !is_write_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         is_write_q <= 1'b0;
         word_q     <= '0;
         wdata_q    <= '0;
         rbuf_q     <= '0;
         rdata_q    <= '0;
         addr_q     <= '0;
         dq_q       <= '0;
         oe_q       <= 1'b0;
         we_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         is_write_q <= is_write_d;
         word_q     <= word_d;
         wdata_q    <= wdata_d;
         rbuf_q     <= rbuf_d;
         rdata_q    <= rdata_d;
         addr_q     <= addr_d;
         dq_q       <= dq_d;
         oe_q       <= oe_d;
         we_n_q     <= we_n_d;
      end
   end

   assign read_data   = (state_q == ST_DONE && !is_write_q) ? rbuf_q : rdata_q;
   assign ready       = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !rd_en && !wr_en);
   assign sram_addr   = addr_q;
   assign sram_dq_out = dq_q;
   assign sram_dq_oe  = oe_q;
   assign sram_we_n   = we_n_q;

endmodule
`default_nettype wire
